pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard/interlock controller for the 5-stage IF/DEC/EXE/MEM/WR core.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fwd_select.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core control logic.
//  fwd_sel_t  : operand forwarding-mux select encoding
//  hz_state_t : hazard controller memory-wait FSM states
//  XZR        : index of the hard-wired zero register
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_EXE = 2'd0,
    FWD_MEM = 2'd1,
    FWD_REG = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN,
    HZ_WAIT
  } hz_state_t;

  localparam int XZR = 31;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for a single source operand.
//  src          : source register index read in DEC
//  exe_aw       : EXE destination index, exe_regwrite its write enable
//  mem_aw       : MEM destination index, mem_regwrite its write enable
//  sel          : FWD_EXE / FWD_MEM / FWD_REG (EXE has priority)
module fwd_select
  import cpu_pkg::*;
#(
  parameter int REGW     = 5,
  parameter int ZERO_REG = XZR
) (
  input  logic [REGW-1:0] src,
  input  logic [REGW-1:0] exe_aw,
  input  logic            exe_regwrite,
  input  logic [REGW-1:0] mem_aw,
  input  logic            mem_regwrite,
  output fwd_sel_t        sel
);

  localparam logic [REGW-1:0] ZR = REGW'(ZERO_REG);

  logic src_live;
  assign src_live = (src != ZR);

  always_comb begin
    sel = FWD_REG;
    if (src_live && exe_regwrite && (exe_aw == src)) begin
      sel = FWD_EXE;
    end else if (src_live && mem_regwrite && (mem_aw == src)) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / interlock controller for the IF/DEC/EXE/MEM/WR pipeline.
//  Inputs : DEC source operands and their use flags, B.LT flag use, DEC redirect,
//           EXE destination/regwrite/load/setflag, MEM destination/regwrite/access.
//  Outputs: rn_sel/rm_sel forwarding selects, pc_stall, ifdec_stall, ifdec_flush,
//           decexe_bubble, exemem_stall, memwr_bubble, stall_cnt, flush_cnt.
//  reset is asynchronous, active-low; while low every control output is idle.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REGW     = 5,
  parameter int ZERO_REG = XZR,
  parameter int MEM_LAT  = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REGW-1:0]  dec_rn,
  input  logic [REGW-1:0]  dec_rm,
  input  logic             dec_use_rn,
  input  logic             dec_use_rm,
  input  logic             dec_use_flags,
  input  logic             dec_redirect,
  input  logic [REGW-1:0]  exe_aw,
  input  logic             exe_regwrite,
  input  logic             exe_memread,
  input  logic             exe_setflag,
  input  logic [REGW-1:0]  mem_aw,
  input  logic             mem_regwrite,
  input  logic             mem_access,
  output logic [1:0]       rn_sel,
  output logic [1:0]       rm_sel,
  output logic             pc_stall,
  output logic             ifdec_stall,
  output logic             ifdec_flush,
  output logic             decexe_bubble,
  output logic             exemem_stall,
  output logic             memwr_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REGW-1:0] ZR        = REGW'(ZERO_REG);
  localparam bit              HAS_WAIT  = (MEM_LAT > 1);
  localparam logic [2:0]      WAIT_LOAD = HAS_WAIT ? 3'(MEM_LAT - 2) : 3'd0;

  // ---------------- forwarding ----------------
  fwd_sel_t rn_fwd, rm_fwd;

  fwd_select #(.REGW(REGW), .ZERO_REG(ZERO_REG)) u_fwd_rn (
    .src          (dec_rn),
    .exe_aw       (exe_aw),
    .exe_regwrite (exe_regwrite),
    .mem_aw       (mem_aw),
    .mem_regwrite (mem_regwrite),
    .sel          (rn_fwd)
  );

  fwd_select #(.REGW(REGW), .ZERO_REG(ZERO_REG)) u_fwd_rm (
    .src          (dec_rm),
    .exe_aw       (exe_aw),
    .exe_regwrite (exe_regwrite),
    .mem_aw       (mem_aw),
    .mem_regwrite (mem_regwrite),
    .sel          (rm_fwd)
  );

  assign rn_sel = reset ? rn_fwd : FWD_REG;
  assign rm_sel = reset ? rm_fwd : FWD_REG;

  // ---------------- interlock detection ----------------
  logic load_use, flag_use, dec_hz;

  assign load_use = exe_memread && exe_regwrite && (exe_aw != ZR) &&
                    ((dec_use_rn && (dec_rn == exe_aw)) ||
                     (dec_use_rm && (dec_rm == exe_aw)));
  assign flag_use = dec_use_flags && exe_setflag;
  assign dec_hz   = load_use || flag_use;

  // ---------------- memory-wait FSM ----------------
  hz_state_t        state_q, state_d;
  logic [2:0]       wait_q, wait_d;
  logic             consumed_q, consumed_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Buffer 3 is held through WAIT, so the finished access is still visible in MEM
  // on the first RUN cycle; consumed_q blocks it from re-arming the wait.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    consumed_d    = 1'b0;
    pc_stall      = 1'b0;
    ifdec_stall   = 1'b0;
    ifdec_flush   = 1'b0;
    decexe_bubble = 1'b0;
    exemem_stall  = 1'b0;
    memwr_bubble  = 1'b0;

    case (state_q)
      HZ_RUN: begin
        pc_stall      = dec_hz;
        ifdec_stall   = dec_hz;
        decexe_bubble = dec_hz;
        ifdec_flush   = dec_redirect && !dec_hz;
        if (HAS_WAIT && mem_access && !consumed_q) begin
          state_d = HZ_WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      HZ_WAIT: begin
        pc_stall     = 1'b1;
        ifdec_stall  = 1'b1;
        exemem_stall = 1'b1;
        memwr_bubble = 1'b1;
        if (wait_q == 3'd0) begin
          state_d    = HZ_RUN;
          consumed_d = 1'b1;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      default: begin
        state_d = HZ_RUN;
        wait_d  = 3'd0;
      end
    endcase

    if (!reset) begin
      pc_stall      = 1'b0;
      ifdec_stall   = 1'b0;
      ifdec_flush   = 1'b0;
      decexe_bubble = 1'b0;
      exemem_stall  = 1'b0;
      memwr_bubble  = 1'b0;
    end
  end

  // ---------------- performance counters ----------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall)    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifdec_flush) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HZ_RUN;
      wait_q      <= 3'd0;
      consumed_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      consumed_q  <= consumed_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_LAT=3): directed scenarios
// followed by random traffic, all checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_LAT = 3;

  logic        clk, reset;
  logic [4:0]  dec_rn, dec_rm, exe_aw, mem_aw;
  logic        dec_use_rn, dec_use_rm, dec_use_flags, dec_redirect;
  logic        exe_regwrite, exe_memread, exe_setflag;
  logic        mem_regwrite, mem_access;
  logic [1:0]  rn_sel, rm_sel;
  logic        pc_stall, ifdec_stall, ifdec_flush, decexe_bubble, exemem_stall, memwr_bubble;
  logic [31:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.REGW(5), .ZERO_REG(31), .MEM_LAT(MEM_LAT), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .dec_rn        (dec_rn),
    .dec_rm        (dec_rm),
    .dec_use_rn    (dec_use_rn),
    .dec_use_rm    (dec_use_rm),
    .dec_use_flags (dec_use_flags),
    .dec_redirect  (dec_redirect),
    .exe_aw        (exe_aw),
    .exe_regwrite  (exe_regwrite),
    .exe_memread   (exe_memread),
    .exe_setflag   (exe_setflag),
    .mem_aw        (mem_aw),
    .mem_regwrite  (mem_regwrite),
    .mem_access    (mem_access),
    .rn_sel        (rn_sel),
    .rm_sel        (rm_sel),
    .pc_stall      (pc_stall),
    .ifdec_stall   (ifdec_stall),
    .ifdec_flush   (ifdec_flush),
    .decexe_bubble (decexe_bubble),
    .exemem_stall  (exemem_stall),
    .memwr_bubble  (memwr_bubble),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining memory-wait cycles, "access just finished" flag, counters.
  int          m_wait_left = 0;
  bit          m_consumed  = 1'b0;
  logic [31:0] m_stall     = '0;
  logic [31:0] m_flush     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] s);
    if (s == 5'd31)                          return 2'd2;
    if (exe_regwrite && (exe_aw == s))       return 2'd0;
    if (mem_regwrite && (mem_aw == s))       return 2'd1;
    return 2'd2;
  endfunction

  task automatic clr();
    dec_rn = 5'd0; dec_rm = 5'd0; exe_aw = 5'd0; mem_aw = 5'd0;
    dec_use_rn = 0; dec_use_rm = 0; dec_use_flags = 0; dec_redirect = 0;
    exe_regwrite = 0; exe_memread = 0; exe_setflag = 0;
    mem_regwrite = 0; mem_access = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rn_sel"}, 32'(rn_sel), 32'd2);
    check({tag, "_rm_sel"}, 32'(rm_sel), 32'd2);
    check({tag, "_ctrl"}, {26'd0, pc_stall, ifdec_stall, ifdec_flush, decexe_bubble,
                           exemem_stall, memwr_bubble}, 32'd0);
    check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    check({tag, "_flush_cnt"}, flush_cnt, 32'd0);
  endtask

  task automatic model_reset();
    m_wait_left = 0; m_consumed = 1'b0; m_stall = '0; m_flush = '0;
  endtask

  // Called just after a falling edge with inputs applied; returns on the next falling edge.
  task automatic step(input string tag);
    bit in_wait, hz, lu;
    bit e_pc, e_bub, e_flush;
    #1;
    in_wait = (m_wait_left > 0);
    lu = exe_memread && exe_regwrite && (exe_aw != 5'd31) &&
         ((dec_use_rn && dec_rn == exe_aw) || (dec_use_rm && dec_rm == exe_aw));
    hz      = lu || (dec_use_flags && exe_setflag);
    e_pc    = in_wait || hz;
    e_bub   = !in_wait && hz;
    e_flush = !in_wait && !hz && dec_redirect;
    check({tag, "_rn_sel"},        32'(rn_sel),        32'(ref_fwd(dec_rn)));
    check({tag, "_rm_sel"},        32'(rm_sel),        32'(ref_fwd(dec_rm)));
    check({tag, "_pc_stall"},      32'(pc_stall),      32'(e_pc));
    check({tag, "_ifdec_stall"},   32'(ifdec_stall),   32'(e_pc));
    check({tag, "_ifdec_flush"},   32'(ifdec_flush),   32'(e_flush));
    check({tag, "_decexe_bubble"}, 32'(decexe_bubble), 32'(e_bub));
    check({tag, "_exemem_stall"},  32'(exemem_stall),  32'(in_wait));
    check({tag, "_memwr_bubble"},  32'(memwr_bubble),  32'(in_wait));
    check({tag, "_stall_cnt"},     stall_cnt,          m_stall);
    check({tag, "_flush_cnt"},     flush_cnt,          m_flush);
    @(posedge clk);
    if (e_pc)    m_stall = m_stall + 32'd1;
    if (e_flush) m_flush = m_flush + 32'd1;
    if (in_wait) begin
      m_wait_left--;
      if (m_wait_left == 0) m_consumed = 1'b1;
    end else begin
      if (mem_access && !m_consumed && MEM_LAT > 1) m_wait_left = MEM_LAT - 1;
      m_consumed = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pool [4];
    pool[0] = 5'd1; pool[1] = 5'd2; pool[2] = 5'd3; pool[3] = 5'd31;

    // Reset state, with inputs that would otherwise forward and stall
    clr();
    reset = 1'b0;
    exe_aw = 5'd4; exe_regwrite = 1; exe_memread = 1; dec_rn = 5'd4; dec_use_rn = 1;
    dec_rm = 5'd4; dec_redirect = 1;
    #3;
    check_idle("reset");
    @(negedge clk);
    clr();
    reset = 1'b1;
    model_reset();

    // 1: EXE forward to Rn, no stall
    exe_aw = 5'd1; exe_regwrite = 1; dec_rn = 5'd1; dec_use_rn = 1;
    step("t1_exe_fwd");

    // 2: EXE wins over MEM, then MEM alone
    clr();
    exe_aw = 5'd2; exe_regwrite = 1; mem_aw = 5'd2; mem_regwrite = 1;
    dec_rm = 5'd2; dec_use_rm = 1;
    step("t2_exe_prio");
    exe_aw = 5'd3;
    step("t2_mem_fwd");

    // 3: load-use stall, then MEM forward
    clr();
    exe_aw = 5'd4; exe_regwrite = 1; exe_memread = 1; dec_rn = 5'd4; dec_use_rn = 1;
    step("t3_load_use");
    clr();
    mem_aw = 5'd4; mem_regwrite = 1; dec_rn = 5'd4; dec_use_rn = 1;
    step("t3_after_load");
    check("t3_stall_cnt_is_1", stall_cnt, 32'd1);

    // 4: flag hazard; XZR never matches
    clr();
    exe_setflag = 1; dec_use_flags = 1;
    step("t4_flag");
    clr();
    exe_aw = 5'd31; exe_regwrite = 1; exe_memread = 1; mem_aw = 5'd31; mem_regwrite = 1;
    dec_rn = 5'd31; dec_use_rn = 1; dec_rm = 5'd31; dec_use_rm = 1;
    step("t4_xzr");

    // 5: redirect alone; redirect held off by load-use
    clr();
    dec_redirect = 1;
    step("t5_redirect");
    check("t5_flush_cnt_is_1", flush_cnt, 32'd1);
    exe_aw = 5'd5; exe_regwrite = 1; exe_memread = 1; dec_rm = 5'd5; dec_use_rm = 1;
    step("t5_redir_stalled");
    clr();
    dec_redirect = 1; mem_aw = 5'd5; mem_regwrite = 1; dec_rm = 5'd5; dec_use_rm = 1;
    step("t5_redir_release");
    check("t5_flush_cnt_is_2", flush_cnt, 32'd2);

    // 6: memory wait, access held in MEM through the wait and the release cycle
    clr();
    mem_access = 1;
    dec_redirect = 1;
    exe_aw = 5'd6; exe_regwrite = 1; exe_memread = 1; dec_rn = 5'd6; dec_use_rn = 1;
    step("t6_enter");
    clr();
    mem_access = 1; dec_redirect = 1;
    step("t6_wait1");
    check("t6_wait1_memwr_bubble", 32'(memwr_bubble), 32'd1);
    step("t6_wait2");
    step("t6_release");
    check("t6_release_no_stall", 32'(pc_stall), 32'd0);
    clr();
    step("t6_idle");

    // 6b: reset during the first WAIT cycle
    mem_access = 1;
    step("t6b_enter");
    clr();
    exe_aw = 5'd7; exe_regwrite = 1; dec_rn = 5'd7; dec_rm = 5'd7;
    #2;
    check("t6b_in_wait", 32'(exemem_stall), 32'd1);
    reset = 1'b0;
    #1;
    check_idle("t6b_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    clr();
    step("t6b_run1");
    step("t6b_run2");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      dec_rn        = pool[$urandom_range(0, 3)];
      dec_rm        = pool[$urandom_range(0, 3)];
      exe_aw        = pool[$urandom_range(0, 3)];
      mem_aw        = pool[$urandom_range(0, 3)];
      dec_use_rn    = 1'($urandom_range(0, 1));
      dec_use_rm    = 1'($urandom_range(0, 1));
      dec_use_flags = ($urandom_range(0, 3) == 0);
      dec_redirect  = ($urandom_range(0, 3) == 0);
      exe_regwrite  = 1'($urandom_range(0, 1));
      exe_memread   = ($urandom_range(0, 2) == 0);
      exe_setflag   = ($urandom_range(0, 3) == 0);
      mem_regwrite  = 1'($urandom_range(0, 1));
      mem_access    = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
